// File: rtl/exception_ctrl.sv
// Exception controller: prioritised entry from decode flags or a synchronised external
// interrupt, one-cycle redirect pulses on handler entry and return, sticky double-fault flag.
module exception_ctrl #(
    parameter logic [63:0] VECTOR_ADDR  = 64'h0000_0000_0000_00D8,
    parameter logic [3:0]  CODE_IRQ     = 4'b0001,
    parameter logic [3:0]  CODE_BADOP   = 4'b0010,
    parameter logic [3:0]  CODE_BADERET = 4'b0011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ExtIRQ,
    input  logic        BadOpcode,
    input  logic        ERet,
    input  logic [63:0] PC_D,
    output logic        PCRedirect,
    output logic [63:0] RedirectPC,
    output logic [63:0] ELR,
    output logic [3:0]  ESR,
    output logic        InExc,
    output logic        DoubleFault
);

    typedef enum logic [1:0] {S_IDLE, S_ENTER, S_HANDLER, S_RETURN} state_t;

    state_t      state_q;
    logic        sync1_q, sync2_q, sync_prev_q;
    logic        irq_pend_q, irq_pend_d;
    logic        irq_take;
    logic [63:0] elr_q;
    logic [3:0]  esr_q;
    logic        dfault_q;

    // A new rising edge of the synchronised level wins over a same-cycle acceptance.
    always_comb begin
        irq_take   = (state_q == S_IDLE) && !BadOpcode && !ERet && irq_pend_q;
        irq_pend_d = (sync2_q && !sync_prev_q) || (irq_pend_q && !irq_take);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            irq_pend_q  <= 1'b0;
            elr_q       <= '0;
            esr_q       <= '0;
            dfault_q    <= 1'b0;
        end else begin
            sync1_q     <= ExtIRQ;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            irq_pend_q  <= irq_pend_d;
            case (state_q)
                S_IDLE: begin
                    if (BadOpcode) begin
                        elr_q   <= PC_D;
                        esr_q   <= CODE_BADOP;
                        state_q <= S_ENTER;
                    end else if (ERet) begin
                        elr_q   <= PC_D;
                        esr_q   <= CODE_BADERET;
                        state_q <= S_ENTER;
                    end else if (irq_pend_q) begin
                        elr_q   <= PC_D;
                        esr_q   <= CODE_IRQ;
                        state_q <= S_ENTER;
                    end
                end
                S_ENTER: state_q <= S_HANDLER;
                S_HANDLER: begin
                    if (BadOpcode) begin
                        dfault_q <= 1'b1;
                    end else if (ERet) begin
                        state_q <= S_RETURN;
                    end
                end
                S_RETURN: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PCRedirect  = (state_q == S_ENTER) || (state_q == S_RETURN);
        RedirectPC  = '0;
        if (state_q == S_ENTER) begin
            RedirectPC = VECTOR_ADDR;
        end else if (state_q == S_RETURN) begin
            RedirectPC = elr_q;
        end
        InExc       = (state_q == S_ENTER) || (state_q == S_HANDLER);
        ELR         = elr_q;
        ESR         = esr_q;
        DoubleFault = dfault_q;
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: entry, return, IRQ latency, priority, double fault, reset.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ExtIRQ = 1'b0;
    logic        BadOpcode = 1'b0;
    logic        ERet = 1'b0;
    logic [63:0] PC_D = '0;
    logic        PCRedirect;
    logic [63:0] RedirectPC;
    logic [63:0] ELR;
    logic [3:0]  ESR;
    logic        InExc;
    logic        DoubleFault;

    int passed = 0;
    int total  = 0;

    exception_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .ExtIRQ     (ExtIRQ),
        .BadOpcode  (BadOpcode),
        .ERet       (ERet),
        .PC_D       (PC_D),
        .PCRedirect (PCRedirect),
        .RedirectPC (RedirectPC),
        .ELR        (ELR),
        .ESR        (ESR),
        .InExc      (InExc),
        .DoubleFault(DoubleFault)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs are sampled and inputs driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if ({PCRedirect, RedirectPC, InExc} !== {1'b0, 64'h0, 1'b0}) begin
            $display("FAIL reset_out: got redir=%0b pc=%h inexc=%0b, want 0/0/0", PCRedirect, RedirectPC, InExc);
        end else passed++;
        total++;
        if ({ELR, ESR, DoubleFault} !== {64'h0, 4'h0, 1'b0}) begin
            $display("FAIL reset_regs: got elr=%h esr=%h df=%0b, want 0/0/0", ELR, ESR, DoubleFault);
        end else passed++;
        reset = 1'b0;
        step();
        total++;
        if ({PCRedirect, RedirectPC, InExc} !== {1'b0, 64'h0, 1'b0}) begin
            $display("FAIL post_reset: got redir=%0b pc=%h inexc=%0b, want 0/0/0", PCRedirect, RedirectPC, InExc);
        end else passed++;
    endtask

    task automatic test_badop_entry();
        PC_D = 64'h40;
        BadOpcode = 1'b1;
        step();
        total++;
        if ({PCRedirect, RedirectPC, ESR, ELR, InExc} !== {1'b1, 64'hD8, 4'b0010, 64'h40, 1'b1}) begin
            $display("FAIL badop_enter: got redir=%0b pc=%h esr=%h elr=%h inexc=%0b, want 1/d8/2/40/1",
                     PCRedirect, RedirectPC, ESR, ELR, InExc);
        end else passed++;
        // BadOpcode still high across the ENTER edge must be ignored.
        PC_D = 64'h44;
        step();
        BadOpcode = 1'b0;
        total++;
        if ({PCRedirect, InExc, DoubleFault, ESR, ELR} !== {1'b0, 1'b1, 1'b0, 4'b0010, 64'h40}) begin
            $display("FAIL badop_handler: got redir=%0b inexc=%0b df=%0b esr=%h elr=%h, want 0/1/0/2/40",
                     PCRedirect, InExc, DoubleFault, ESR, ELR);
        end else passed++;
    endtask

    task automatic test_eret_return();
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        BadOpcode = 1'b1;
        total++;
        if ({PCRedirect, RedirectPC, InExc} !== {1'b1, 64'h40, 1'b0}) begin
            $display("FAIL return_redir: got redir=%0b pc=%h inexc=%0b, want 1/40/0", PCRedirect, RedirectPC, InExc);
        end else passed++;
        // BadOpcode sampled in RETURN must not start an exception.
        step();
        BadOpcode = 1'b0;
        total++;
        if ({PCRedirect, RedirectPC, InExc, ESR, ELR} !== {1'b0, 64'h0, 1'b0, 4'b0010, 64'h40}) begin
            $display("FAIL return_idle: got redir=%0b pc=%h inexc=%0b esr=%h elr=%h, want 0/0/0/2/40",
                     PCRedirect, RedirectPC, InExc, ESR, ELR);
        end else passed++;
        step();
        total++;
        if ({PCRedirect, InExc} !== 2'b00) begin
            $display("FAIL idle_stays: got redir=%0b inexc=%0b, want 0/0", PCRedirect, InExc);
        end else passed++;
    endtask

    task automatic test_irq();
        int n = 0;
        int extra = 0;
        PC_D = 64'h100;
        ExtIRQ = 1'b1;
        while (PCRedirect !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        total++;
        if (PCRedirect !== 1'b1 || n > 4) begin
            $display("FAIL irq_latency: got redir=%0b after %0d edges, want 1 within 4", PCRedirect, n);
        end else passed++;
        total++;
        if ({RedirectPC, ESR, ELR, InExc} !== {64'hD8, 4'b0001, 64'h100, 1'b1}) begin
            $display("FAIL irq_enter: got pc=%h esr=%h elr=%h inexc=%0b, want d8/1/100/1", RedirectPC, ESR, ELR, InExc);
        end else passed++;
        step();
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        total++;
        if ({PCRedirect, RedirectPC} !== {1'b1, 64'h100}) begin
            $display("FAIL irq_return: got redir=%0b pc=%h, want 1/100", PCRedirect, RedirectPC);
        end else passed++;
        for (int i = 0; i < 10; i++) begin
            step();
            if (PCRedirect === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            $display("FAIL irq_held: got %0d extra redirect cycles, want 0", extra);
        end else passed++;
        ExtIRQ = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_priority();
        ExtIRQ = 1'b1;
        step();
        step();
        step();
        PC_D = 64'h80;
        BadOpcode = 1'b1;
        step();
        BadOpcode = 1'b0;
        total++;
        if ({PCRedirect, ESR, ELR} !== {1'b1, 4'b0010, 64'h80}) begin
            $display("FAIL prio_badop: got redir=%0b esr=%h elr=%h, want 1/2/80", PCRedirect, ESR, ELR);
        end else passed++;
        step();
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        PC_D = 64'hC0;
        total++;
        if ({PCRedirect, RedirectPC} !== {1'b1, 64'h80}) begin
            $display("FAIL prio_return: got redir=%0b pc=%h, want 1/80", PCRedirect, RedirectPC);
        end else passed++;
        step();
        total++;
        if ({PCRedirect, InExc} !== 2'b00) begin
            $display("FAIL prio_idle: got redir=%0b inexc=%0b, want 0/0", PCRedirect, InExc);
        end else passed++;
        step();
        total++;
        if ({PCRedirect, RedirectPC, ESR, ELR} !== {1'b1, 64'hD8, 4'b0001, 64'hC0}) begin
            $display("FAIL prio_irq_later: got redir=%0b pc=%h esr=%h elr=%h, want 1/d8/1/c0",
                     PCRedirect, RedirectPC, ESR, ELR);
        end else passed++;
        ExtIRQ = 1'b0;
        step();
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        step();
    endtask

    task automatic test_double_fault();
        PC_D = 64'h200;
        BadOpcode = 1'b1;
        step();
        BadOpcode = 1'b0;
        step();
        BadOpcode = 1'b1;
        ERet = 1'b1;
        step();
        BadOpcode = 1'b0;
        ERet = 1'b0;
        total++;
        if ({PCRedirect, InExc, DoubleFault, ESR, ELR} !== {1'b0, 1'b1, 1'b1, 4'b0010, 64'h200}) begin
            $display("FAIL dfault_set: got redir=%0b inexc=%0b df=%0b esr=%h elr=%h, want 0/1/1/2/200",
                     PCRedirect, InExc, DoubleFault, ESR, ELR);
        end else passed++;
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        step();
        total++;
        if ({PCRedirect, InExc, DoubleFault} !== {1'b0, 1'b0, 1'b1}) begin
            $display("FAIL dfault_sticky: got redir=%0b inexc=%0b df=%0b, want 0/0/1", PCRedirect, InExc, DoubleFault);
        end else passed++;
        PC_D = 64'h20;
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        total++;
        if ({PCRedirect, ESR, ELR} !== {1'b1, 4'b0011, 64'h20}) begin
            $display("FAIL bad_eret: got redir=%0b esr=%h elr=%h, want 1/3/20", PCRedirect, ESR, ELR);
        end else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        total++;
        if ({InExc, DoubleFault} !== 2'b11) begin
            $display("FAIL pre_reset_handler: got inexc=%0b df=%0b, want 1/1", InExc, DoubleFault);
        end else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({PCRedirect, RedirectPC, InExc, ELR, ESR, DoubleFault} !== {1'b0, 64'h0, 1'b0, 64'h0, 4'h0, 1'b0}) begin
            $display("FAIL async_reset: got redir=%0b pc=%h inexc=%0b elr=%h esr=%h df=%0b, want all 0",
                     PCRedirect, RedirectPC, InExc, ELR, ESR, DoubleFault);
        end else passed++;
        step();
        reset = 1'b0;
        step();
        total++;
        if ({PCRedirect, InExc, DoubleFault} !== 3'b000) begin
            $display("FAIL after_reset: got redir=%0b inexc=%0b df=%0b, want 0/0/0", PCRedirect, InExc, DoubleFault);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_badop_entry();
        test_eret_return();
        test_irq();
        test_priority();
        test_double_fault();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter VECTOR_ADDR, default 64'h0000_0000_0000_00D8, exception handler entry address.
REQ-002 Parameter CODE_IRQ, default 4'b0001, ESR cause for external interrupt.
REQ-003 Parameter CODE_BADOP, default 4'b0010, ESR cause for invalid opcode.
REQ-004 Parameter CODE_BADERET, default 4'b0011, ESR cause for ERET outside handler.
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ExtIRQ  input  1  external interrupt request, asynchronous level.
REQ-008 BadOpcode  input  1  decode-stage flag: opcode matched no known format.
REQ-009 ERet  input  1  decode-stage flag: ERET instruction decoded.
REQ-010 PC_D  input  64  PC of the instruction currently in decode.
REQ-011 PCRedirect  output  1  one-cycle request to load RedirectPC and flush the front end.
REQ-012 RedirectPC  output  64  target address when PCRedirect=1; 64'h0 otherwise.
REQ-013 ELR  output  64  exception link register, saved return PC.
REQ-014 ESR  output  4  exception syndrome, cause of last accepted exception.
REQ-015 InExc  output  1  handler mode; high in ENTER and HANDLER.
REQ-016 DoubleFault  output  1  sticky flag: exception raised while in handler mode.

Function
REQ-017 FSM states: IDLE, ENTER, HANDLER, RETURN; state register only; all outputs decoded from registered state and registers (no input-to-output combinational path).
REQ-018 ExtIRQ passes through a 2-flop synchronizer; a rising edge of the synchronized level sets irq_pend; irq_pend clears only when the IRQ is accepted.
REQ-019 IDLE, BadOpcode=1: ELR<=PC_D, ESR<=CODE_BADOP, next=ENTER.
REQ-020 IDLE, BadOpcode=0, ERet=1: ELR<=PC_D, ESR<=CODE_BADERET, next=ENTER.
REQ-021 IDLE, BadOpcode=0, ERet=0, irq_pend=1: ELR<=PC_D, ESR<=CODE_IRQ, irq_pend<=0, next=ENTER.
REQ-022 Priority in IDLE: BadOpcode > ERet > irq_pend; a losing irq_pend stays set and is taken in a later IDLE cycle.
REQ-023 ENTER (exactly 1 cycle): PCRedirect=1, RedirectPC=VECTOR_ADDR; next=HANDLER unconditionally; inputs ignored.
REQ-024 HANDLER, ERet=1 and BadOpcode=0: next=RETURN.
REQ-025 HANDLER, BadOpcode=1: DoubleFault<=1, stay HANDLER, ELR/ESR unchanged; ERet same cycle is ignored.
REQ-026 HANDLER: irq_pend may set but is never accepted (interrupts masked).
REQ-027 RETURN (exactly 1 cycle): PCRedirect=1, RedirectPC=ELR; next=IDLE; inputs ignored; no exception accepted in RETURN.
REQ-028 Latency: flag sampled at edge N -> PCRedirect high during cycle N+1; ERet in HANDLER at edge N -> return redirect in cycle N+1.
REQ-029 Synchronizer latency: ExtIRQ rising edge reaches irq_pend in 3 edges worst case; minimum entry latency 4 cycles.
REQ-030 ExtIRQ held high produces exactly one exception; a new one needs a low-then-high transition.
REQ-031 ELR and ESR hold their values in every state except at acceptance per REQ-019..021.
REQ-032 InExc=1 in ENTER and HANDLER, 0 in IDLE and RETURN.

Reset
REQ-033 reset=1 asynchronously forces state=IDLE, synchronizer flops=0, irq_pend=0, ELR=64'h0, ESR=4'h0, DoubleFault=0.
REQ-034 During and immediately after reset: PCRedirect=0, RedirectPC=64'h0, InExc=0.
REQ-035 Reset asserted mid-ENTER, HANDLER or RETURN aborts the sequence without a redirect pulse; DoubleFault clears only by reset.

Verification
REQ-036 IDLE, PC_D=64'h40, BadOpcode=1 for one edge -> next cycle PCRedirect=1, RedirectPC=64'hD8, ESR=4'b0010, ELR=64'h40, InExc=1; then HANDLER.
REQ-037 In HANDLER, ERet=1 one edge -> next cycle PCRedirect=1, RedirectPC=64'h40, InExc=0; following cycle IDLE, PCRedirect=0.
REQ-038 ExtIRQ rises with PC_D=64'h100, no other flags -> within 4 cycles PCRedirect=1 to 64'hD8, ESR=4'b0001, ELR=64'h100; ExtIRQ held high -> no second entry after return.
REQ-039 BadOpcode=1 at the same edge irq_pend=1, PC_D=64'h80 -> ESR=4'b0010; after ERET/RETURN, next IDLE cycle accepts IRQ, ESR=4'b0001.
REQ-040 In HANDLER, BadOpcode=1 -> DoubleFault=1 stays set, no redirect, ELR/ESR unchanged; ERet in IDLE with PC_D=64'h20 -> ESR=4'b0011, ELR=64'h20.
REQ-041 reset pulsed during HANDLER -> all outputs return to REQ-033/034 values asynchronously, including DoubleFault=0.
